payload_len_chk: RTL and testbench

//  Receive-side counterpart of the transmitter payload-length splitter. Loads the same total byte count,

---
 rtl/eth_len_pkg.sv | 15 +
 rtl/payload_len_pred.sv | 30 +++
 rtl/payload_len_chk.sv | 126 ++++++++++++
 tb/tb_payload_len_chk.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_len_pkg.sv
// Shared constants and FSM state type for the Ethernet payload-length splitter/checker pair.
package eth_len_pkg;

  localparam int DEF_LEN_W        = 16;
  localparam int DEF_MAX_PAYLOAD  = 1500;
  localparam int DEF_SPLIT_THRESH = 1600;
  localparam int DEF_FCNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/payload_len_pred.sv
// Predicts the next frame's payload length from the bytes still outstanding.
// Pure combinational, so the TX splitter can reuse it and stay in lock-step.
module payload_len_pred
  import eth_len_pkg::*;
#(
  parameter int LEN_W        = DEF_LEN_W,
  parameter int MAX_PAYLOAD  = DEF_MAX_PAYLOAD,
  parameter int SPLIT_THRESH = DEF_SPLIT_THRESH
) (
  input  logic [LEN_W-1:0] i_remain,
  output logic [LEN_W-1:0] o_expected_len
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_PAYLOAD);
  localparam logic [LEN_W-1:0] THR_L = LEN_W'(SPLIT_THRESH);

  // Between MAX_PAYLOAD and SPLIT_THRESH the tail is halved so neither of the
  // last two frames ends up runt-sized.
  // NOTE: every branch assigns o_expected_len, so no latch is inferred.
  always_comb begin
    if (i_remain > THR_L) begin
      o_expected_len = MAX_L;
    end else if (i_remain > MAX_L) begin
      o_expected_len = i_remain >> 1;
    end else begin
      o_expected_len = i_remain;
    end
  end

endmodule

// File: rtl/payload_len_chk.sv
// RX payload-length checker: counts bytes per frame on an 8-bit AXI-Stream and
// compares each closed frame against the length the TX segmentation rule predicts.
module payload_len_chk
  import eth_len_pkg::*;
#(
  parameter int LEN_W        = DEF_LEN_W,
  parameter int MAX_PAYLOAD  = DEF_MAX_PAYLOAD,
  parameter int SPLIT_THRESH = DEF_SPLIT_THRESH,
  parameter int FCNT_W       = DEF_FCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  total_bytes,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              frame_done,
  output logic [LEN_W-1:0]  frame_len,
  output logic [LEN_W-1:0]  expected_len,
  output logic              len_err,
  output logic              err_sticky,
  output logic              xfer_done,
  output logic [LEN_W-1:0]  remain,
  output logic [FCNT_W-1:0] frame_cnt
);

  state_t              r_state;
  logic [LEN_W-1:0]    r_byte_cnt;
  logic [LEN_W-1:0]    r_remain;
  logic [LEN_W-1:0]    r_frame_len;
  logic [FCNT_W-1:0]   r_frame_cnt;
  logic                r_frame_done;
  logic                r_len_err;
  logic                r_err_sticky;
  logic                r_xfer_done;

  logic [LEN_W-1:0]    w_expected_len;
  logic [LEN_W:0]      w_cnt_p1;
  logic [LEN_W-1:0]    w_cnt_sat;
  logic [LEN_W-1:0]    w_remain_next;
  logic                w_beat;

  payload_len_pred #(
    .LEN_W       (LEN_W),
    .MAX_PAYLOAD (MAX_PAYLOAD),
    .SPLIT_THRESH(SPLIT_THRESH)
  ) u_pred (
    .i_remain      (r_remain),
    .o_expected_len(w_expected_len)
  );

  assign s_axis_tready = (r_state == ST_RUN);
  assign w_beat        = s_axis_tvalid & s_axis_tready;

  // One extra bit only to detect the carry; the count sticks at all-ones.
  assign w_cnt_p1      = {1'b0, r_byte_cnt} + 1'b1;
  assign w_cnt_sat     = w_cnt_p1[LEN_W] ? {LEN_W{1'b1}} : w_cnt_p1[LEN_W-1:0];

  // The predicted length never exceeds remain, so this cannot wrap.
  assign w_remain_next = r_remain - w_expected_len;

  // NOTE: state registers use non-blocking assignments so every read in this
  // block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_byte_cnt   <= '0;
      r_remain     <= '0;
      r_frame_len  <= '0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
      r_len_err    <= 1'b0;
      r_err_sticky <= 1'b0;
      r_xfer_done  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_len_err    <= 1'b0;
      r_xfer_done  <= 1'b0;

      if (start) begin
        // Start wins over a same-cycle beat and silently drops any open frame.
        r_remain     <= total_bytes;
        r_byte_cnt   <= '0;
        r_frame_cnt  <= '0;
        r_err_sticky <= 1'b0;
        if (total_bytes == '0) begin
          r_state     <= ST_DONE;
          r_xfer_done <= 1'b1;
        end else begin
          r_state     <= ST_RUN;
        end
      end else if (w_beat) begin
        if (s_axis_tlast) begin
          r_frame_len  <= w_cnt_sat;
          r_byte_cnt   <= '0;
          r_frame_done <= 1'b1;
          r_len_err    <= (w_cnt_sat != w_expected_len);
          if (w_cnt_sat != w_expected_len) begin
            r_err_sticky <= 1'b1;
          end
          // Subtract the predicted length so we track the transmitter even
          // when the received frame was short or long.
          r_remain     <= w_remain_next;
          r_frame_cnt  <= r_frame_cnt + 1'b1;
          if (w_remain_next == '0) begin
            r_state     <= ST_DONE;
            r_xfer_done <= 1'b1;
          end
        end else begin
          r_byte_cnt <= w_cnt_sat;
        end
      end
    end
  end

  assign frame_done   = r_frame_done;
  assign frame_len    = r_frame_len;
  assign expected_len = w_expected_len;
  assign len_err      = r_len_err;
  assign err_sticky   = r_err_sticky;
  assign xfer_done    = r_xfer_done;
  assign remain       = r_remain;
  assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_payload_len_chk.sv
// Directed plus randomized bench for payload_len_chk; expectations come from a
// per-transfer frame plan built from the segmentation rule.
module tb_payload_len_chk;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] total_bytes;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic        frame_done;
  logic [15:0] frame_len;
  logic [15:0] expected_len;
  logic        len_err;
  logic        err_sticky;
  logic        xfer_done;
  logic [15:0] remain;
  logic [7:0]  frame_cnt;

  payload_len_chk dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .total_bytes  (total_bytes),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .frame_done   (frame_done),
    .frame_len    (frame_len),
    .expected_len (expected_len),
    .len_err      (len_err),
    .err_sticky   (err_sticky),
    .xfer_done    (xfer_done),
    .remain       (remain),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: the list of frame lengths the transfer should split into,
  // plus the running totals a receiver would track.
  int m_plan[$];
  int m_remain;
  int m_fcnt;
  bit m_sticky;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void build_plan(input int total);
    int r;
    int e;
    m_plan.delete();
    r = total;
    while (r > 0) begin
      if (r > 1600)      e = 1500;
      else if (r > 1500) e = r / 2;
      else               e = r;
      m_plan.push_back(e);
      r -= e;
    end
  endfunction

  task automatic do_start(input int total);
    start       = 1'b1;
    total_bytes = 16'(total);
    tick();
    start         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_remain = total;
    m_fcnt   = 0;
    m_sticky = 1'b0;
    build_plan(total);
    chk("start_remain",   remain,        total);
    chk("start_fcnt",     frame_cnt,     0);
    chk("start_sticky",   err_sticky,    0);
    chk("start_fdone",    frame_done,    0);
    chk("start_tready",   s_axis_tready, (total != 0));
    chk("start_xfer",     xfer_done,     (total == 0));
  endtask

  // Sends one frame of n bytes with random valid gaps, then checks the close-out.
  task automatic send_frame(input int n);
    int exp_len;
    int sent;
    exp_len = m_plan.pop_front();
    chk("exp_len", expected_len, exp_len);
    sent = 0;
    while (sent < n) begin
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tlast  = s_axis_tvalid && (sent == n - 1);
      tick();
      if (s_axis_tvalid) sent++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_remain -= exp_len;
    m_fcnt    = (m_fcnt + 1) % 256;
    if (n != exp_len) m_sticky = 1'b1;
    chk("frame_done", frame_done,    1);
    chk("frame_len",  frame_len,     n);
    chk("len_err",    len_err,       (n != exp_len));
    chk("err_sticky", err_sticky,    m_sticky);
    chk("remain",     remain,        m_remain);
    chk("frame_cnt",  frame_cnt,     m_fcnt);
    chk("xfer_done",  xfer_done,     (m_remain == 0));
    chk("tready",     s_axis_tready, (m_remain != 0));
    tick();
    chk("fdone_pulse", frame_done, 0);
    chk("lerr_pulse",  len_err,    0);
    chk("xfer_pulse",  xfer_done,  0);
    chk("flen_held",   frame_len,  n);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tready"}, s_axis_tready, 0);
    chk({tag, "_fdone"},  frame_done,    0);
    chk({tag, "_flen"},   frame_len,     0);
    chk({tag, "_explen"}, expected_len,  0);
    chk({tag, "_lerr"},   len_err,       0);
    chk({tag, "_sticky"}, err_sticky,    0);
    chk({tag, "_xfer"},   xfer_done,     0);
    chk({tag, "_remain"}, remain,        0);
    chk({tag, "_fcnt"},   frame_cnt,     0);
  endtask

  initial begin
    int total;
    int n;
    rst           = 1'b1;
    start         = 1'b0;
    total_bytes   = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // 3000 -> 1500 + 1500
    do_start(3000);
    send_frame(1500);
    send_frame(1500);

    // 1550 -> 775 + 775 (halving band)
    do_start(1550);
    send_frame(775);
    send_frame(775);

    // 1601 -> 1500 + 101
    do_start(1601);
    send_frame(1500);
    send_frame(101);

    // Short frame: mismatch still closes out the transfer
    do_start(1000);
    send_frame(999);

    // Zero-length transfer: DONE, beats ignored
    do_start(0);
    tick();
    chk("zero_xfer_pulse", xfer_done, 0);
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk("zero_tready", s_axis_tready, 0);
    chk("zero_fdone",  frame_done,    0);
    chk("zero_fcnt",   frame_cnt,     0);

    // Abort mid-frame; restart coincides with a tlast beat that must be dropped
    do_start(3000);
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    for (int i = 0; i < 400; i++) tick();
    s_axis_tlast  = 1'b1;
    do_start(200);
    send_frame(200);

    // Back-to-back single-byte frames with tlast every cycle
    do_start(1600);
    chk("b2b_exp0", expected_len, m_plan[0]);
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b1;
    tick();
    m_remain -= m_plan.pop_front();
    chk("b2b_fdone0",  frame_done, 1);
    chk("b2b_flen0",   frame_len,  1);
    chk("b2b_lerr0",   len_err,    1);
    chk("b2b_remain0", remain,     m_remain);
    chk("b2b_exp1",    expected_len, m_plan[0]);
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_remain -= m_plan.pop_front();
    chk("b2b_fdone1",  frame_done, 1);
    chk("b2b_flen1",   frame_len,  1);
    chk("b2b_remain1", remain,     m_remain);
    chk("b2b_fcnt",    frame_cnt,  2);
    chk("b2b_xfer",    xfer_done,  1);
    chk("b2b_sticky",  err_sticky, 1);
    tick();
    chk("b2b_tready", s_axis_tready, 0);

    // Reset mid-frame after an error has set the sticky flag
    do_start(3000);
    send_frame(1499);
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    tick();
    do_start(1500);
    send_frame(1500);

    // Random transfers, some frames deliberately one byte off
    for (int k = 0; k < 6; k++) begin
      total = $urandom_range(1, 3300);
      do_start(total);
      while (m_plan.size() != 0) begin
        n = m_plan[0];
        if ($urandom_range(0, 3) == 0) n = n + int'($urandom_range(0, 2)) - 1;
        if (n < 1) n = 1;
        send_frame(n);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
